// File: rtl/serial_comparator_pkg.sv
// Shared types for the serial comparator: FSM states, relation codes and
// small helpers that fold digit results into a relation.
package serial_comparator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // REL_NONE means "no differing digit seen yet".
   typedef enum logic [1:0] {
      REL_NONE = 2'd0,
      REL_GT   = 2'd1,
      REL_EQ   = 2'd2,
      REL_LT   = 2'd3
   } rel_t;

   // Keep an already decided relation; otherwise let the current digit decide.
   function automatic rel_t rel_resolve(input rel_t decided,
                                        input logic dig_gt,
                                        input logic dig_eq,
                                        input logic dig_lt);
      rel_t res;
      res = REL_NONE;
      if (decided != REL_NONE) begin
         res = decided;
      end else if (dig_eq) begin
         res = REL_NONE;
      end else if (dig_gt) begin
         res = REL_GT;
      end else if (dig_lt) begin
         res = REL_LT;
      end
      return res;
   endfunction

   // Relation to {gt, eq, lt} flags.
   function automatic logic [2:0] rel_flags(input rel_t rel);
      logic [2:0] f;
      f = 3'b000;
      case (rel)
         REL_GT:  f = 3'b100;
         REL_EQ:  f = 3'b010;
         REL_LT:  f = 3'b001;
         default: f = 3'b000;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational magnitude comparator for a single DIGIT-bit digit.
module digit_compare #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   output logic             o_gt,
   output logic             o_eq,
   output logic             o_lt
);

   // Unsigned relation of the two digits.
   always_comb begin
      o_gt = (i_a > i_b);
      o_eq = (i_a == i_b);
      o_lt = (i_a < i_b);
   end

endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle magnitude comparator: walks the operands DIGIT bits per clock,
// most significant digit first, and reports gt/eq/lt with a done pulse.
// Signed compares are reduced to unsigned by flipping the MSBs at latch time.
module serial_comparator
   import serial_comparator_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   // Guarded divisor so the derived constants stay defined even when the
   // parameter check below is about to reject the configuration.
   localparam int DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
   localparam int K        = (WIDTH / DIG_SAFE < 1) ? 1 : WIDTH / DIG_SAFE;
   localparam int CNT_W    = (K > 1) ? $clog2(K) : 1;
   localparam int SH_W     = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

   if (DIGIT < 1) begin : g_bad_digit
      $error("serial_comparator: DIGIT must be >= 1");
   end else if (WIDTH < 2) begin : g_bad_width
      $error("serial_comparator: WIDTH must be >= 2");
   end else if ((WIDTH % DIG_SAFE) != 0) begin : g_bad_ratio
      $error("serial_comparator: WIDTH must be a multiple of DIGIT");
   end

   state_t             r_state;
   rel_t               r_rel;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_busy;
   logic               r_done;
   logic               r_gt;
   logic               r_eq;
   logic               r_lt;

   logic [CNT_W-1:0]   w_sel;
   logic [SH_W-1:0]    w_shamt;
   logic [DIGIT-1:0]   w_a_dig;
   logic [DIGIT-1:0]   w_b_dig;
   logic               w_dig_gt;
   logic               w_dig_eq;
   logic               w_dig_lt;
   rel_t               w_rel_next;
   rel_t               w_rel_final;

   // Select the current digit (counter 0 addresses the most significant one).
   always_comb begin
      w_sel   = CNT_LAST - r_cnt;
      w_shamt = SH_W'(w_sel) * SH_W'(DIG_SAFE);
      w_a_dig = DIGIT'(r_a >> w_shamt);
      w_b_dig = DIGIT'(r_b >> w_shamt);
   end

   digit_compare #(
      .DIGIT (DIGIT)
   ) u_digit_compare (
      .i_a  (w_a_dig),
      .i_b  (w_b_dig),
      .o_gt (w_dig_gt),
      .o_eq (w_dig_eq),
      .o_lt (w_dig_lt)
   );

   // Fold the current digit into the running relation; an undecided
   // relation after the last digit means the operands are equal.
   always_comb begin
      w_rel_next  = rel_resolve(r_rel, w_dig_gt, w_dig_eq, w_dig_lt);
      w_rel_final = (w_rel_next == REL_NONE) ? REL_EQ : w_rel_next;
   end

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_rel   <= REL_NONE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
         r_lt    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (signed_mode) begin
                     r_a <= {~a[WIDTH-1], a[WIDTH-2:0]};
                     r_b <= {~b[WIDTH-1], b[WIDTH-2:0]};
                  end else begin
                     r_a <= a;
                     r_b <= b;
                  end
                  r_cnt   <= '0;
                  r_rel   <= REL_NONE;
                  r_gt    <= 1'b0;
                  r_eq    <= 1'b0;
                  r_lt    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               r_rel <= w_rel_next;
               if (r_cnt == CNT_LAST) begin
                  {r_gt, r_eq, r_lt} <= rel_flags(w_rel_final);
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign gt   = r_gt;
   assign eq   = r_eq;
   assign lt   = r_lt;

endmodule
